// File: rtl/mpt_plb.sv
// Protection Lookaside Buffer: fully-associative cache of {SDID, SPA page} -> MPT permissions.
// Optional build macro MPT_PLB_PERF_CNT_EN adds 32-bit hit/miss counter ports.

package mpt_plb_pkg;
    localparam int XLEN     = 64;
    localparam int SDID_LEN = 6;
    localparam int PPN_W    = XLEN - 12;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_EXEC  = 2'd3
    } mpt_access_e;

    // Bit 0 = read, bit 1 = write, bit 2 = execute.
    typedef enum logic [2:0] {
        ALLOW_NONE = 3'd0,
        ALLOW_R    = 3'd1,
        ALLOW_W    = 3'd2,
        ALLOW_RW   = 3'd3,
        ALLOW_X    = 3'd4,
        ALLOW_RX   = 3'd5,
        ALLOW_WX   = 3'd6,
        ALLOW_RWX  = 3'd7
    } mpt_permissions_e;

    typedef struct packed {
        logic [SDID_LEN-1:0] sdid;
        logic [XLEN-1:0]     spa;
        mpt_access_e         access_type;
    } plb_lookup_req_t;

    typedef struct packed {
        logic [SDID_LEN-1:0] sdid;
        logic [XLEN-1:0]     spa;
        mpt_permissions_e    perms;
    } plb_entry_t;
endpackage

module mpt_plb
    import mpt_plb_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                lookup_valid_i,
    output logic                lookup_ready_o,
    input  plb_lookup_req_t     lookup_req_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic                resp_hit_o,
    output logic                resp_allow_o,
    output logic [2:0]          resp_perms_o,
    input  logic                fill_valid_i,
    input  plb_entry_t          fill_entry_i,
    input  logic                flush_i,
    input  logic                flush_sdid_valid_i,
    input  logic [SDID_LEN-1:0] flush_sdid_i
`ifdef MPT_PLB_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
`endif
);
    localparam int PTR_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_FLUSH} state_e;

    state_e                state_q, state_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [SDID_LEN-1:0]   ent_sdid_q  [NUM_ENTRIES];
    logic [PPN_W-1:0]      ent_ppn_q   [NUM_ENTRIES];
    mpt_permissions_e      ent_perms_q [NUM_ENTRIES];
    logic [PTR_W-1:0]      repl_ptr_q, repl_ptr_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  flush_all_q, flush_all_d;
    logic [SDID_LEN-1:0]   flush_sdid_q, flush_sdid_d;
    logic [PTR_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                  resp_hit_q, resp_hit_d;
    logic                  resp_allow_q, resp_allow_d;
    mpt_permissions_e      resp_perms_q, resp_perms_d;

    logic                  lk_hit, lk_allow;
    mpt_permissions_e      lk_perms;
    logic                  lookup_fire;
    logic                  fill_en, fill_match, fill_free;
    logic [PTR_W-1:0]      fill_match_idx, fill_free_idx, fill_idx;
    logic                  flush_done;

    // Page-offset bits never take part in a tag compare.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{lookup_req_i.spa[11:0], fill_entry_i.spa[11:0]};

    // NOTE: every always_comb assigns a default first so no path leaves a variable unassigned (no latches).
    always_comb begin
        lk_hit   = 1'b0;
        lk_perms = ALLOW_NONE;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && ent_sdid_q[i] == lookup_req_i.sdid &&
                ent_ppn_q[i] == lookup_req_i.spa[XLEN-1:12]) begin
                lk_hit   = 1'b1;
                lk_perms = ent_perms_q[i];
            end
        end
        unique case (lookup_req_i.access_type)
            ACC_READ:  lk_allow = lk_perms[0];
            ACC_WRITE: lk_allow = lk_perms[1];
            ACC_EXEC:  lk_allow = lk_perms[2];
            default:   lk_allow = 1'b0;
        endcase
    end

    // Fill victim: existing tag, else lowest free slot, else round-robin pointer.
    always_comb begin
        fill_match     = 1'b0;
        fill_match_idx = '0;
        fill_free      = 1'b0;
        fill_free_idx  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && ent_sdid_q[i] == fill_entry_i.sdid &&
                ent_ppn_q[i] == fill_entry_i.spa[XLEN-1:12] && !fill_match) begin
                fill_match     = 1'b1;
                fill_match_idx = PTR_W'(i);
            end
            if (!valid_q[i] && !fill_free) begin
                fill_free     = 1'b1;
                fill_free_idx = PTR_W'(i);
            end
        end
        fill_en    = fill_valid_i && (state_q != ST_FLUSH);
        fill_idx   = fill_match ? fill_match_idx : (fill_free ? fill_free_idx : repl_ptr_q);
        repl_ptr_d = (fill_en && !fill_match && !fill_free) ? repl_ptr_q + PTR_W'(1) : repl_ptr_q;
    end

    always_comb begin
        flush_done   = (state_q == ST_FLUSH) && (flush_cnt_q == PTR_W'(NUM_ENTRIES - 1));
        flush_cnt_d  = (state_q == ST_FLUSH) ? flush_cnt_q + PTR_W'(1) : '0;
        flush_pend_d = flush_pend_q;
        flush_all_d  = flush_all_q;
        flush_sdid_d = flush_sdid_q;
        if (flush_done) flush_pend_d = 1'b0;
        if (flush_i) begin
            if (flush_pend_d) begin
                flush_all_d = 1'b1;
            end else begin
                flush_pend_d = 1'b1;
                flush_all_d  = !flush_sdid_valid_i;
                flush_sdid_d = flush_sdid_i;
            end
        end

        valid_d = valid_q;
        if (fill_en) valid_d[fill_idx] = 1'b1;
        if (state_q == ST_FLUSH &&
            (flush_all_q || ent_sdid_q[flush_cnt_q] == flush_sdid_q)) begin
            valid_d[flush_cnt_q] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_pend_q)        state_d = ST_FLUSH;
                else if (lookup_valid_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    if (lookup_valid_i && !flush_pend_q) state_d = ST_RESP;
                    else if (flush_pend_q)               state_d = ST_FLUSH;
                    else                                 state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lookup_ready_o = ((state_q == ST_IDLE) || (state_q == ST_RESP && resp_ready_i)) &&
                         !flush_pend_q && (state_q != ST_FLUSH);
        resp_valid_o   = (state_q == ST_RESP);
        lookup_fire    = lookup_valid_i && lookup_ready_o;
        resp_hit_d     = lookup_fire ? lk_hit   : resp_hit_q;
        resp_allow_d   = lookup_fire ? lk_allow : resp_allow_q;
        resp_perms_d   = lookup_fire ? lk_perms : resp_perms_q;
    end

    assign resp_hit_o   = resp_hit_q;
    assign resp_allow_o = resp_allow_q;
    assign resp_perms_o = resp_perms_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            repl_ptr_q   <= '0;
            flush_pend_q <= 1'b0;
            flush_all_q  <= 1'b0;
            flush_sdid_q <= '0;
            flush_cnt_q  <= '0;
            resp_hit_q   <= 1'b0;
            resp_allow_q <= 1'b0;
            resp_perms_q <= ALLOW_NONE;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            repl_ptr_q   <= repl_ptr_d;
            flush_pend_q <= flush_pend_d;
            flush_all_q  <= flush_all_d;
            flush_sdid_q <= flush_sdid_d;
            flush_cnt_q  <= flush_cnt_d;
            resp_hit_q   <= resp_hit_d;
            resp_allow_q <= resp_allow_d;
            resp_perms_q <= resp_perms_d;
        end
    end

    // NOTE: entry payload is not reset; the valid bits alone decide whether it is ever observed.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            ent_sdid_q[fill_idx]  <= fill_entry_i.sdid;
            ent_ppn_q[fill_idx]   <= fill_entry_i.spa[XLEN-1:12];
            ent_perms_q[fill_idx] <= fill_entry_i.perms;
        end
    end

`ifdef MPT_PLB_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (lookup_fire) begin
            if (lk_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else        miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mpt_plb.sv
// Self-checking bench for mpt_plb: directed scenarios plus random traffic against an
// entry-table reference model of the PLB's tag/replacement/flush rules.

module tb_mpt_plb;
    import mpt_plb_pkg::*;

    localparam int NE = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                lookup_valid_i = 1'b0;
    logic                lookup_ready_o;
    plb_lookup_req_t     lookup_req_i = '0;
    logic                resp_valid_o;
    logic                resp_ready_i = 1'b0;
    logic                resp_hit_o;
    logic                resp_allow_o;
    logic [2:0]          resp_perms_o;
    logic                fill_valid_i = 1'b0;
    plb_entry_t          fill_entry_i = '0;
    logic                flush_i = 1'b0;
    logic                flush_sdid_valid_i = 1'b0;
    logic [SDID_LEN-1:0] flush_sdid_i = '0;
`ifdef MPT_PLB_PERF_CNT_EN
    logic [31:0]         hit_cnt_o, miss_cnt_o;
`endif

    mpt_plb #(.NUM_ENTRIES(NE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
        .lookup_req_i(lookup_req_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_hit_o(resp_hit_o), .resp_allow_o(resp_allow_o), .resp_perms_o(resp_perms_o),
        .fill_valid_i(fill_valid_i), .fill_entry_i(fill_entry_i),
        .flush_i(flush_i), .flush_sdid_valid_i(flush_sdid_valid_i), .flush_sdid_i(flush_sdid_i)
`ifdef MPT_PLB_PERF_CNT_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a table of cached translations plus the round-robin pointer.
    bit                  m_valid [NE];
    logic [SDID_LEN-1:0] m_sdid  [NE];
    logic [PPN_W-1:0]    m_ppn   [NE];
    logic [2:0]          m_perms [NE];
    int                  m_ptr;
    int                  m_hits, m_misses;

    function automatic void model_clear();
        for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
        m_ptr = 0; m_hits = 0; m_misses = 0;
    endfunction

    function automatic void model_fill(input logic [SDID_LEN-1:0] s, input logic [63:0] a,
                                       input logic [2:0] p);
        int slot = -1;
        for (int i = 0; i < NE; i++)
            if (slot < 0 && m_valid[i] && m_sdid[i] == s && m_ppn[i] == a[63:12]) slot = i;
        for (int i = 0; i < NE; i++)
            if (slot < 0 && !m_valid[i]) slot = i;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % NE;
        end
        m_valid[slot] = 1'b1; m_sdid[slot] = s; m_ppn[slot] = a[63:12]; m_perms[slot] = p;
    endfunction

    function automatic void model_lookup(input logic [SDID_LEN-1:0] s, input logic [63:0] a,
                                         input mpt_access_e acc,
                                         output bit h, output logic [2:0] p, output bit al);
        h = 1'b0; p = 3'd0; al = 1'b0;
        for (int i = 0; i < NE; i++)
            if (m_valid[i] && m_sdid[i] == s && m_ppn[i] == a[63:12]) begin
                h = 1'b1; p = m_perms[i];
            end
        case (acc)
            ACC_READ:  al = p[0];
            ACC_WRITE: al = p[1];
            ACC_EXEC:  al = p[2];
            default:   al = 1'b0;
        endcase
    endfunction

    function automatic void model_flush(input bit all, input logic [SDID_LEN-1:0] s);
        for (int i = 0; i < NE; i++)
            if (all || m_sdid[i] == s) m_valid[i] = 1'b0;
    endfunction

    // All tasks start and end just after a falling edge; inputs change there.
    task automatic tb_reset();
        rst_ni = 1'b0;
        lookup_valid_i = 0; resp_ready_i = 0; fill_valid_i = 0; flush_i = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_clear();
        @(negedge clk_i);
    endtask

    task automatic lookup(input string tag, input logic [SDID_LEN-1:0] s, input logic [63:0] a,
                          input mpt_access_e acc, input int hold);
        bit h, al; logic [2:0] p; int n = 0;
        lookup_valid_i = 1'b1;
        lookup_req_i   = '{sdid: s, spa: a, access_type: acc};
        while (!lookup_ready_o && n < 100) begin
            @(negedge clk_i); n++;
        end
        if (n == 100) check({tag, "_ready_timeout"}, 0, 1);
        model_lookup(s, a, acc, h, p, al);
        if (h) m_hits++; else m_misses++;
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
        check({tag, "_valid"}, resp_valid_o, 1);
        check({tag, "_hit"}, resp_hit_o, h);
        check({tag, "_perms"}, resp_perms_o, p);
        check({tag, "_allow"}, resp_allow_o, al);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk_i);
            check({tag, "_hold_hit"}, {resp_valid_o, resp_hit_o, resp_allow_o, resp_perms_o},
                  {1'b1, h, al, p});
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
    endtask

    task automatic fill(input logic [SDID_LEN-1:0] s, input logic [63:0] a, input logic [2:0] p,
                        input bit dropped);
        fill_valid_i = 1'b1;
        fill_entry_i = '{sdid: s, spa: a, perms: mpt_permissions_e'(p)};
        @(negedge clk_i);
        fill_valid_i = 1'b0;
        if (!dropped) model_fill(s, a, p);
    endtask

    task automatic flush(input string tag, input bit sel, input logic [SDID_LEN-1:0] s);
        int n = 0;
        flush_i = 1'b1; flush_sdid_valid_i = sel; flush_sdid_i = s;
        @(negedge clk_i);
        flush_i = 1'b0;
        model_flush(!sel, s);
        while (!lookup_ready_o && n < 4 * NE) begin
            n++; @(negedge clk_i);
        end
        check({tag, "_busy_min"}, n >= NE, 1);
        check({tag, "_busy_max"}, n <= NE + 2, 1);
    endtask

    function automatic logic [63:0] page_addr(input int base, input int pg, input int off);
        return (64'(base) << 32) | (64'(pg) << 12) | 64'(off);
    endfunction

    logic [2:0] held_p;
    logic       held_h, held_a;

    initial begin
        tb_reset();
        check("rst_state", {resp_valid_o, resp_hit_o, resp_allow_o, resp_perms_o, lookup_ready_o},
              7'b000_0001);
`ifdef MPT_PLB_PERF_CNT_EN
        check("rst_cnt", {hit_cnt_o, miss_cnt_o}, 64'd0);
`endif

        // Cold miss, then a single READ-only page probed with several access types.
        lookup("t1_miss", 3, 64'h8000_1234, ACC_READ, 0);
        fill(3, 64'h8000_1000, 3'b001, 0);
        lookup("t2_read",  3, 64'h8000_1FFC, ACC_READ, 0);
        lookup("t2_write", 3, 64'h8000_1FFC, ACC_WRITE, 0);
        lookup("t2_exec",  3, 64'h8000_1FFC, ACC_EXEC, 1);
        lookup("t2_none",  3, 64'h8000_1FFC, ACC_NONE, 0);
        lookup("t2_sdid4", 4, 64'h8000_1FFC, ACC_READ, 0);
        fill(3, 64'h8000_1000, 3'b110, 0);
        lookup("t2_refill", 3, 64'h8000_1004, ACC_WRITE, 0);

        // Back-to-back: second lookup offered while the first response is consumed.
        lookup_valid_i = 1'b1;
        lookup_req_i   = '{sdid: 3, spa: 64'h8000_1000, access_type: ACC_READ};
        @(negedge clk_i);
        lookup_req_i   = '{sdid: 3, spa: 64'h8000_1000, access_type: ACC_EXEC};
        resp_ready_i   = 1'b1;
        m_misses += 0; m_hits += 2;
        @(negedge clk_i);
        lookup_valid_i = 1'b0; resp_ready_i = 1'b0;
        check("b2b_resp", {resp_valid_o, resp_hit_o, resp_allow_o, resp_perms_o}, 6'b111_110);
        resp_ready_i = 1'b1; @(negedge clk_i); resp_ready_i = 1'b0;

        // Stalled response with a fill then a flush arriving while it is held.
        lookup_valid_i = 1'b1;
        lookup_req_i   = '{sdid: 3, spa: 64'h8000_1FFC, access_type: ACC_WRITE};
        model_lookup(3, 64'h8000_1FFC, ACC_WRITE, held_h, held_p, held_a);
        m_hits++;
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                fill_valid_i = 1'b1;
                fill_entry_i = '{sdid: 5, spa: 64'hA000_0000, perms: ALLOW_RWX};
            end
            if (k == 2) begin
                flush_i = 1'b1; flush_sdid_valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (k == 1) model_fill(5, 64'hA000_0000, 3'b111);
            fill_valid_i = 1'b0; flush_i = 1'b0;
            check("t5_stall_out", {resp_valid_o, resp_hit_o, resp_allow_o, resp_perms_o},
                  {1'b1, held_h, held_a, held_p});
            if (k >= 2) check("t5_ready_low", lookup_ready_o, 0);
        end
        model_flush(1, 0);
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        check("t5_flush_after_hs", {resp_valid_o, lookup_ready_o}, 2'b00);
        @(negedge clk_i);
        fill(5, 64'hB000_0000, 3'b111, 1);
        begin
            int n = 0;
            while (!lookup_ready_o && n < 4 * NE) begin
                n++; @(negedge clk_i);
            end
            check("t5_flush_end", lookup_ready_o, 1);
        end
        lookup("t5_fillA", 5, 64'hA000_0010, ACC_READ, 0);
        lookup("t5_fillB", 5, 64'hB000_0010, ACC_READ, 0);
        lookup("t5_orig",  3, 64'h8000_1FFC, ACC_READ, 0);

        // Capacity: NE+1 distinct pages evict entry 0, the next evicts entry 1.
        tb_reset();
        for (int i = 0; i <= NE; i++) fill(1, page_addr(1, i, 0), 3'b011, 0);
        lookup("t3_first", 1, page_addr(1, 0, 8), ACC_READ, 0);
        lookup("t3_last",  1, page_addr(1, NE, 8), ACC_WRITE, 0);
        fill(1, page_addr(1, NE + 1, 0), 3'b100, 0);
        lookup("t3_ptr1",  1, page_addr(1, 1, 0), ACC_READ, 0);
        lookup("t3_keep2", 1, page_addr(1, 2, 0), ACC_READ, 0);

        // Selective flush of SDID 2.
        tb_reset();
        for (int i = 0; i < 3; i++) begin
            fill(1, page_addr(2, i, 0), 3'b001, 0);
            fill(2, page_addr(2, i, 0), 3'b001, 0);
        end
        flush("t4_flush", 1, 2);
        for (int i = 0; i < 3; i++) begin
            lookup("t4_sdid1", 1, page_addr(2, i, 4), ACC_READ, 0);
            lookup("t4_sdid2", 2, page_addr(2, i, 4), ACC_READ, 0);
        end

        // Random traffic over a small page pool so hits, evictions and flushes interleave.
        tb_reset();
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 19);
            logic [SDID_LEN-1:0] s = SDID_LEN'($urandom_range(1, 3));
            logic [63:0] a = page_addr(3, $urandom_range(0, 11), $urandom_range(0, 4095));
            if (r < 11)
                lookup("rnd", s, a, mpt_access_e'($urandom_range(0, 3)), $urandom_range(0, 2));
            else if (r < 19)
                fill(s, a, 3'($urandom_range(0, 7)), 0);
            else
                flush("rnd_flush", 1'($urandom_range(0, 1)), s);
        end
`ifdef MPT_PLB_PERF_CNT_EN
        check("rnd_hit_cnt",  hit_cnt_o,  32'(m_hits));
        check("rnd_miss_cnt", miss_cnt_o, 32'(m_misses));
`endif

        // Counters, then reset asserted in the middle of a flush.
        tb_reset();
        for (int i = 0; i < 3; i++) fill(1, page_addr(4, i, 0), 3'b001, 0);
        for (int i = 0; i < 3; i++) lookup("t6_hit", 1, page_addr(4, i, 0), ACC_READ, 0);
        for (int i = 3; i < 5; i++) lookup("t6_miss", 1, page_addr(4, i, 0), ACC_READ, 0);
`ifdef MPT_PLB_PERF_CNT_EN
        check("t6_hit_cnt",  hit_cnt_o,  32'd3);
        check("t6_miss_cnt", miss_cnt_o, 32'd2);
`endif
        flush_i = 1'b1; flush_sdid_valid_i = 1'b1; flush_sdid_i = 7;
        @(negedge clk_i);
        flush_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("t6_in_flush", lookup_ready_o, 0);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_async", {resp_valid_o, resp_hit_o, lookup_ready_o}, 3'b001);
`ifdef MPT_PLB_PERF_CNT_EN
        check("t6_rst_cnt", {hit_cnt_o, miss_cnt_o}, 64'd0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_clear();
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) lookup("t6_post_rst", 1, page_addr(4, i, 0), ACC_READ, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
